// File: rtl/muldiv_if.sv
// Handshake and operand bus between the pipeline and the RV32M multiply/divide sequencer.
interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, flush, funct3, data1, data2, input busy, done, result);
  modport slave  (input start, flush, funct3, data1, data2, output busy, done, result);
endinterface

// File: rtl/muldiv_sequencer.sv
// RV32M multiply (single cycle) / restoring divide (XLEN steps + sign fix) sequencer.
// Optional macro MULDIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow complete straight from accept.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input logic     clk_i,
  input logic     rst_i,
  muldiv_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t          state_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] rem_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic [XLEN:0]   shift_w;
  logic [XLEN:0]   trial_w;
  logic            sgn_w;

  // Operands extended to 2*XLEN; the low 2*XLEN bits of the product are exact for every sign mix.
  function automatic logic [XLEN-1:0] mul_word(input logic [1:0] op,
                                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic            sa;
    logic            sb;
    logic [2*XLEN-1:0] ax;
    logic [2*XLEN-1:0] bx;
    logic [2*XLEN-1:0] p;
    sa = (op == 2'b01) || (op == 2'b10);
    sb = (op == 2'b01);
    ax = {{XLEN{sa & a[XLEN-1]}}, a};
    bx = {{XLEN{sb & b[XLEN-1]}}, b};
    p  = ax * bx;
    return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  function automatic logic [XLEN-1:0] div_fix(input logic want_rem, input logic neg_quo,
                                              input logic neg_rem, input logic [XLEN-1:0] quo,
                                              input logic [XLEN-1:0] rem);
    if (want_rem) return neg_rem ? -rem : rem;
    return neg_quo ? -quo : quo;
  endfunction

  assign sgn_w   = !bus.funct3[0];
  assign shift_w = {rem_q, a_q[XLEN-1]};
  assign trial_w = shift_w - {1'b0, b_q};

`ifdef MULDIV_FAST_SPECIAL_EN
  logic            special_w;
  logic [XLEN-1:0] special_res_w;

  always_comb begin
    special_w = bus.funct3[2] && ((bus.data2 == '0) ||
                (!bus.funct3[0] && bus.data1 == {1'b1, {(XLEN-1){1'b0}}} && (&bus.data2)));
    if (bus.data2 == '0) special_res_w = bus.funct3[1] ? bus.data1 : '1;
    else                 special_res_w = bus.funct3[1] ? '0 : bus.data1;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cnt_q    <= '0;
    end else if (bus.flush) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (bus.start) begin
            op_q  <= bus.funct3[1:0];
            cnt_q <= '0;
`ifdef MULDIV_FAST_SPECIAL_EN
            if (special_w) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= special_res_w;
            end else
`endif
            if (bus.funct3[2]) begin
              // Divide runs on magnitudes; a zero divisor keeps the all-ones quotient unsigned.
              state_q   <= S_DIV;
              busy_q    <= 1'b1;
              a_q       <= (sgn_w && bus.data1[XLEN-1]) ? -bus.data1 : bus.data1;
              b_q       <= (sgn_w && bus.data2[XLEN-1]) ? -bus.data2 : bus.data2;
              rem_q     <= '0;
              neg_quo_q <= sgn_w && (bus.data1[XLEN-1] ^ bus.data2[XLEN-1]) && (bus.data2 != '0);
              neg_rem_q <= sgn_w && bus.data1[XLEN-1];
            end else begin
              state_q <= S_MUL;
              busy_q  <= 1'b1;
              a_q     <= bus.data1;
              b_q     <= bus.data2;
            end
          end
        end
        S_MUL: begin
          result_q <= mul_word(op_q, a_q, b_q);
          state_q  <= S_DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
        S_DIV: begin
          if (!trial_w[XLEN]) begin
            rem_q <= trial_w[XLEN-1:0];
            a_q   <= {a_q[XLEN-2:0], 1'b1};
          end else begin
            rem_q <= shift_w[XLEN-1:0];
            a_q   <= {a_q[XLEN-2:0], 1'b0};
          end
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN-1)) state_q <= S_FIX;
        end
        S_FIX: begin
          result_q <= div_fix(op_q[1], neg_quo_q, neg_rem_q, a_q, rem_q);
          state_q  <= S_DONE;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(XLEN)) bus ();
  muldiv_sequencer #(.XLEN(XLEN)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    r = '0;
    case (op)
      3'd0: begin p = 64'(ua * ub); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic special;
    if (!op[2]) return 1;
    special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef MULDIV_FAST_SPECIAL_EN
    return special ? 0 : 33;
`else
    if (special) return 33;
    return 33;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.funct3 = op;
    bus.data1  = a;
    bus.data2  = b;
    tick();
    bus.start  = 1'b0;
    bus.funct3 = 3'($urandom);
    bus.data1  = $urandom;
    bus.data2  = $urandom;
  endtask

  // Random STARTs while busy must be ignored; START is dropped as soon as DONE is seen.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc = 0;
    bcnt = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.busy === 1'b1) bcnt++;
      bus.start  = 1'($urandom);
      bus.funct3 = 3'($urandom);
      tick();
      cyc++;
    end
    bus.start = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int cyc, bcnt;
    launch(op, a, b);
    wait_done(cyc, bcnt);
    check({tag, " result"}, bus.result, ref_result(op, a, b));
    check({tag, " latency"}, 32'(cyc), 32'(exp_lat(op, a, b)));
    check({tag, " busy cycles"}, 32'(bcnt), 32'(exp_lat(op, a, b)));
    check({tag, " busy at done"}, {31'b0, bus.busy}, 32'h0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, held;
    logic [2:0]  op;
    logic        saw_done;
    int          cyc, bcnt, mode;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.funct3 = '0;
    bus.data1 = '0;
    bus.data2 = '0;
    repeat (3) tick();
    check("reset busy", {31'b0, bus.busy}, 32'h0);
    check("reset done", {31'b0, bus.done}, 32'h0);
    check("reset result", bus.result, 32'h0);
    rst = 1'b0;
    tick();

    // Directed cases, issued back-to-back from each DONE cycle
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul 7*-3");
    check("mul 7*-3 const", bus.result, 32'hFFFF_FFEB);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
    check("mulhu const", bus.result, 32'hFFFF_FFFE);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh");
    check("mulh const", bus.result, 32'h0000_0000);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    check("mulhsu const", bus.result, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div -7/2");
    check("div -7/2 const", bus.result, 32'hFFFF_FFFD);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem -7/2");
    check("rem -7/2 const", bus.result, 32'hFFFF_FFFF);
    run_op(3'd5, 32'd5, 32'd0, "divu 5/0");
    check("divu 5/0 const", bus.result, 32'hFFFF_FFFF);
    run_op(3'd7, 32'd5, 32'd0, "remu 5/0");
    check("remu 5/0 const", bus.result, 32'd5);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
    check("div ovf const", bus.result, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem ovf");
    check("rem ovf const", bus.result, 32'h0);
    tick();
    check("done one-cycle pulse", {31'b0, bus.done}, 32'h0);
    check("result held idle", bus.result, 32'h0);

    // Flush at E10 of a divide, with a simultaneous START that must not be taken
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul pre-flush");
    tick();
    launch(3'd4, 32'd100, 32'd7);
    repeat (9) tick();
    check("busy before flush", {31'b0, bus.busy}, 32'h1);
    bus.flush = 1'b1;
    bus.start = 1'b1;
    bus.funct3 = 3'd0;
    bus.data1 = 32'd3;
    bus.data2 = 32'd5;
    tick();
    check("flush busy", {31'b0, bus.busy}, 32'h0);
    check("flush done", {31'b0, bus.done}, 32'h0);
    check("flush result held", bus.result, 32'hFFFF_FFEB);
    bus.flush = 1'b0;
    tick();
    bus.start = 1'b0;
    check("restart after flush busy", {31'b0, bus.busy}, 32'h1);
    wait_done(cyc, bcnt);
    check("restart after flush result", bus.result, 32'd15);
    check("restart after flush latency", 32'(cyc), 32'd1);

    // Reset at E5 of a divide overrides START and FLUSH and emits no DONE
    tick();
    launch(3'd4, 32'd1000, 32'd3);
    repeat (4) tick();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    tick();
    check("mid reset busy", {31'b0, bus.busy}, 32'h0);
    check("mid reset done", {31'b0, bus.done}, 32'h0);
    check("mid reset result", bus.result, 32'h0);
    rst = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
    end
    check("no activity after mid reset", {31'b0, saw_done}, 32'h0);

    // Randomized operations with biased operands
    for (int n = 0; n < 150; n++) begin
      op = 3'($urandom);
      mode = int'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      if (mode == 0) b = 32'h0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) begin
        a = 32'(int'($urandom_range(0, 40)) - 20);
        b = 32'(int'($urandom_range(0, 10)) - 5);
      end
      run_op(op, a, b, $sformatf("rnd%0d op%0d", n, op));
      if ($urandom_range(0, 2) == 0) begin
        held = ref_result(op, a, b);
        tick();
        check("rnd done cleared", {31'b0, bus.done}, 32'h0);
        check("rnd result held", bus.result, held);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter XLEN, default 32: operand/result width; counter width SHALL be clog2(XLEN)+1.
REQ-002 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 START  input  1  request; sampled only when BUSY=0.
REQ-005 FLUSH  input  1  pipeline flush; abandons any operation in flight.
REQ-006 FUNCT3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 DATA1  input  XLEN  rs1 operand (dividend / multiplicand).
REQ-008 DATA2  input  XLEN  rs2 operand (divisor / multiplier).
REQ-009 BUSY  output  1  high in states MUL, DIV, FIX; drives pipeline stall.
REQ-010 DONE  output  1  one-cycle pulse, high only in state DONE.
REQ-011 RESULT  output  XLEN  registered result; valid when DONE=1, held until the next accepted START.

Function
REQ-012 States SHALL be IDLE, MUL, DIV, FIX, DONE; START accepted at edge E0 when BUSY=0 and FLUSH=0.
REQ-013 Accept: FUNCT3, DATA1, DATA2 latched at E0; START while BUSY=1 SHALL be ignored.
REQ-014 Accept from DONE state SHALL be allowed (back-to-back); otherwise DONE->IDLE.
REQ-015 MUL path: E0->MUL; at E1 64-bit product latched, low word for MUL, high word for MULH/MULHSU/MULHU; state->DONE; DONE high in cycle after E1.
REQ-016 MULH signed x signed, MULHSU signed DATA1 x unsigned DATA2, MULHU unsigned x unsigned.
REQ-017 DIV path: E0->DIV with magnitudes latched for signed ops; edges E1..E32 perform one restoring shift-subtract step each; after E32 ->FIX.
REQ-018 FIX: at E33 sign correction applied (quotient negated if signs differ; remainder takes dividend sign); ->DONE; DONE high in cycle after E33.
REQ-019 Divide by zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = DATA1.
REQ-020 Signed overflow (DATA1=0x80000000, DATA2=0xFFFFFFFF, DIV/REM): DIV result 0x80000000, REM result 0.
REQ-021 FLUSH=1 at any edge SHALL force IDLE, suppress DONE, leave RESULT unchanged; FLUSH with START SHALL not accept.
REQ-022 No combinational path from inputs to BUSY, DONE or RESULT.

Reset
REQ-023 RESET=1 at an edge SHALL force IDLE, BUSY=0, DONE=0, RESULT=0, counter=0; RESET overrides START and FLUSH.
REQ-024 RESET mid-operation SHALL discard the operation with no DONE pulse.

Configuration
REQ-025 Macro MULDIV_FAST_SPECIAL_EN defined: divide-by-zero and signed-overflow cases SHALL go E0->DONE directly, DONE high in cycle after E0, BUSY never asserted.
REQ-026 Macro undefined: those cases SHALL run the full 33-edge DIV/FIX path with results per REQ-019/020.

Verification
REQ-027 MUL, DATA1=7, DATA2=-3 -> RESULT 0xFFFFFFEB, DONE one cycle after E1, BUSY high one cycle.
REQ-028 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-029 DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF, DONE exactly after E33, BUSY high 33 cycles.
REQ-030 DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; DIV 0x80000000/-1 -> 0x80000000; latency checked per macro setting.
REQ-031 FLUSH at E10 of a DIV -> IDLE at E10, no DONE, RESULT holds prior value; new START at next edge accepted.
REQ-032 RESET at E5 of a DIV, and START asserted in DONE cycle -> reset clears all outputs; back-to-back START accepted with no idle gap.
